// File: rtl/nrdiv_32bit_if.sv
// Start/busy/done handshake bundle for the 32-bit divide unit.
interface nrdiv_32bit_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/nrdiv_32bit.sv
// Sequential 32-bit non-restoring divider, one add/sub per cycle.
// Define NRDIV_SIGNED_EN for two's complement operands (truncating toward zero).
module nrdiv_32bit (
  input  logic         clk,
  input  logic         rst_n,
  nrdiv_32bit_if.slave bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [W:0]      p;
  logic [W-1:0]    q;
  logic [W:0]      d;
  logic [CW-1:0]   cnt;
  logic            dz_stage;
  logic            busy_r;
  logic            done_r;
  logic            dz_r;
  logic [W-1:0]    quot_r;
  logic [W-1:0]    rem_r;
`ifdef NRDIV_SIGNED_EN
  logic            neg_q;
  logic            neg_r;
`endif

  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic [W:0]      p_shift;
  logic [W:0]      p_step;
  logic [W:0]      p_fix;
  logic [W-1:0]    q_fix;
  logic [W-1:0]    r_fix;

  // Operand magnitudes, one iteration step, and final correction/sign fix-up.
  always_comb begin
    a_mag   = bus.dividend;
    b_mag   = bus.divisor;
`ifdef NRDIV_SIGNED_EN
    if (bus.dividend[W-1]) a_mag = (~bus.dividend) + W'(1);
    if (bus.divisor[W-1])  b_mag = (~bus.divisor) + W'(1);
`endif
    p_shift = {p[W-1:0], q[W-1]};
    p_step  = p[W] ? (p_shift + d) : (p_shift - d);
    p_fix   = p[W] ? (p + d) : p;
    q_fix   = q;
    r_fix   = p_fix[W-1:0];
`ifdef NRDIV_SIGNED_EN
    if (neg_q) q_fix = (~q) + W'(1);
    if (neg_r) r_fix = (~p_fix[W-1:0]) + W'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      p        <= '0;
      q        <= '0;
      d        <= '0;
      cnt      <= '0;
      dz_stage <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dz_r     <= 1'b0;
      quot_r   <= '0;
      rem_r    <= '0;
`ifdef NRDIV_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          // The cycle after a done pulse still reports busy, so start is ignored there.
          if (done_r) begin
            busy_r <= 1'b0;
          end else if (!busy_r && bus.start) begin
            busy_r <= 1'b1;
            if (bus.divisor == '0) begin
              q        <= '1;
              p        <= {1'b0, bus.dividend};
              dz_stage <= 1'b1;
              state    <= DONE;
            end else begin
              q        <= a_mag;
              p        <= '0;
              d        <= {1'b0, b_mag};
              cnt      <= CW'(W - 1);
              dz_stage <= 1'b0;
`ifdef NRDIV_SIGNED_EN
              neg_q    <= bus.dividend[W-1] ^ bus.divisor[W-1];
              neg_r    <= bus.dividend[W-1];
`endif
              state    <= CALC;
            end
          end
        end
        CALC: begin
          p <= p_step;
          q <= {q[W-2:0], ~p_step[W]};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - CW'(1);
        end
        FIX: begin
          q     <= q_fix;
          p     <= {1'b0, r_fix};
          state <= DONE;
        end
        DONE: begin
          quot_r <= q;
          rem_r  <= p[W-1:0];
          dz_r   <= dz_stage;
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dz_r;
endmodule

// File: tb/tb_nrdiv_32bit.sv
// Self-checking bench for nrdiv_32bit: vector table, scoreboard, handshake and reset corners.
module tb_nrdiv_32bit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nrdiv_32bit_if bus ();
  nrdiv_32bit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.dz = (b == 32'd0);
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else begin
`ifdef NRDIV_SIGNED_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000;
        e.r = 32'd0;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
`else
      e.q = a / b;
      e.r = a % b;
`endif
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for idle, then present one accepted start and record its expectation.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    int g = 0;
    while (bus.busy && g < 100) begin
      tick();
      g++;
    end
    if (bus.busy) check("idle_timeout", 32'(bus.busy), 32'd0);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    sb.push_back(model(a, b));
    tick();
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  task automatic wait_done(input int exp_lat, input string name);
    int   n = 0;
    exp_t e;
    do begin
      tick();
      n++;
    end while (!bus.done && n < 45);
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    if (bus.done && sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_quotient"}, bus.quotient, e.q);
      check({name, "_remainder"}, bus.remainder, e.r);
      check({name, "_dbz"}, 32'(bus.div_by_zero), 32'(e.dz));
      check({name, "_busy_at_done"}, 32'(bus.busy), 32'd1);
    end
    tick();
    check({name, "_busy_after"}, 32'(bus.busy), 32'd0);
    check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input string name);
    start_op(a, b);
    wait_done((b == 32'd0) ? 1 : 34, name);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int seen;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;

    vecs.push_back('{32'd100,         32'd7,          '{32'd14,          32'd2,    1'b0}});
    vecs.push_back('{32'hFFFF_FFFF,   32'd1,          '{32'hFFFF_FFFF,   32'd0,    1'b0}});
    vecs.push_back('{32'd5,           32'd9,          '{32'd0,           32'd5,    1'b0}});
    vecs.push_back('{32'd1234,        32'd0,          '{32'hFFFF_FFFF,   32'd1234, 1'b1}});
    vecs.push_back('{32'd0,           32'd5,          '{32'd0,           32'd0,    1'b0}});
    vecs.push_back('{32'hFFFF_FFFF,   32'hFFFF_FFFF,  '{32'd1,           32'd0,    1'b0}});
`ifdef NRDIV_SIGNED_EN
    vecs.push_back('{32'hFFFF_FFF9,   32'd2,          '{32'hFFFF_FFFD,   32'hFFFF_FFFF, 1'b0}});
    vecs.push_back('{32'd7,           32'hFFFF_FFFE,  '{32'hFFFF_FFFD,   32'd1,    1'b0}});
    vecs.push_back('{32'h8000_0000,   32'hFFFF_FFFF,  '{32'h8000_0000,   32'd0,    1'b0}});
    vecs.push_back('{32'h8000_0000,   32'd3,          '{32'hD555_5556,   32'hFFFF_FFFE, 1'b0}});
`else
    vecs.push_back('{32'hFFFF_FFF9,   32'd2,          '{32'h7FFF_FFFC,   32'd1,    1'b0}});
    vecs.push_back('{32'h8000_0000,   32'd3,          '{32'h2AAA_AAAA,   32'd2,    1'b0}});
`endif
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      vecs.push_back('{ra, rb, model(ra, rb)});
    end

    // Reset state
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_quotient", bus.quotient, 32'd0);
    check("rst_remainder", bus.remainder, 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    tick();

    // Table: bench-owned expectations cross-checked through the scoreboard
    for (int i = 0; i < vecs.size(); i++) begin
      start_op(vecs[i].a, vecs[i].b);
      sb[sb.size()-1] = vecs[i].e;
      wait_done((vecs[i].b == 32'd0) ? 1 : 34, $sformatf("vec%0d", i));
    end

    // Starts during busy (cycle 5 and from cycle 34 on) are ignored; first idle edge accepts
    start_op(32'd100, 32'd7);
    repeat (4) tick();
    bus.start = 1'b1; bus.dividend = 32'd999; bus.divisor = 32'd5;
    tick();
    bus.start = 1'b0;
    repeat (28) tick();
    bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    tick();
    check("hs_done_e34", 32'(bus.done), 32'd1);
    check("hs_quotient", bus.quotient, 32'd14);
    check("hs_remainder", bus.remainder, 32'd2);
    void'(sb.pop_front());
    tick();
    check("hs_busy_e35", 32'(bus.busy), 32'd0);
    sb.push_back(model(32'd1000, 32'd3));
    tick();
    check("hs_busy_e36", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_done(34, "hs_next");

    // Reset at cycle 10 aborts with no done
    start_op(32'd100, 32'd7);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_quotient", bus.quotient, 32'd0);
    check("abort_remainder", bus.remainder, 32'd0);
    check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
    sb.delete();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_div(32'd100, 32'd7, "after_abort");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/nrdiv_32bit.md
# nrdiv_32bit

Sequential 32-bit non-restoring divider: accepts a dividend/divisor pair on a start pulse and returns quotient and remainder after a fixed number of cycles. Each iteration performs one 33-bit add or subtract of the divisor against the partial remainder, so this is the iterative inverse of the 32-bit add/sub datapath. Sits beside the arithmetic/logic blocks as the long-latency divide unit and is driven by a simple start/busy/done handshake.

## Interface
- No parameters; width fixed at 32.
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only when busy=0
- dividend  input  32  captured on accepted start
- divisor  input  32  captured on accepted start
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse, results valid
- quotient  output  32  result, held until next done
- remainder  output  32  result, held until next done
- div_by_zero  output  1  qualifies current results; held with them

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: start=1 and divisor!=0 -> capture operands, clear the 33-bit partial remainder, load a 5-bit iteration counter with 31, go to CALC. If start=1 and divisor==0, go to DONE with quotient=32'hFFFF_FFFF, remainder=dividend, div_by_zero=1.
- CALC, one iteration per cycle: shift {P,Q} left by 1. If P was non-negative, P=P-D; otherwise P=P+D. The new quotient bit is the inverted sign of the new P. When the counter reaches 0, go to FIX; otherwise decrement.
- FIX: if P<0, P=P+D. Load quotient and remainder, set div_by_zero=0, go to DONE.
- DONE: done=1 for this cycle only, then return to IDLE.
- start while busy=1 (including the DONE cycle) is ignored; it is not queued.
- Operands are sampled only at acceptance. Input changes afterwards have no effect.
- All arithmetic is 33-bit two's complement on P; quotient and remainder are truncated to 32 bits.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE; busy, done, div_by_zero=0; quotient, remainder=0. Reset overrides all other activity.
- Reset mid-operation aborts the divide. No done is produced, and results read 0.
- Normal latency: start accepted at edge E0. Cycles 1-32 are CALC, cycle 33 is FIX, cycle 34 is DONE.
- The done pulse and valid results appear after edge E34, and busy falls after edge E35.
- Divide-by-zero latency: done is high after E1, and busy falls after E2.
- Back-to-back operation: the earliest next start is accepted at the first edge where busy=0.
- Results change only when entering DONE.

## Configuration
- NRDIV_SIGNED_EN defined: operands are two's complement.
  - Magnitudes are taken at capture. FIX applies the signs: the quotient is negated if the operand signs differ, and the remainder takes the sign of the dividend. The quotient truncates toward zero.
  - Overflow case: 32'h8000_0000 / 32'hFFFF_FFFF gives quotient=32'h8000_0000, remainder=0.
  - Divide by zero gives quotient=32'hFFFF_FFFF and remainder=dividend.
  - Latency is unchanged.
- Not defined: unsigned operation only. There is no sign logic, and all values are treated as unsigned.

## Test plan
- Unsigned divide: reset, then start with 100 / 7 -> done exactly 34 cycles after the start edge; quotient=14, remainder=2, div_by_zero=0; busy=0 one cycle later.
- Corner values: 32'hFFFF_FFFF / 1 -> quotient=32'hFFFF_FFFF, remainder=0. Then 5 / 9 -> quotient=0, remainder=5.
- Divide by zero: 1234 / 0 -> done 1 cycle after start; quotient=32'hFFFF_FFFF, remainder=1234, div_by_zero=1.
- Handshake: assert start again at cycles 5 and 34 of a divide with different operands -> both ignored and the results match the first operands. A start at the first idle cycle is accepted and completes 34 cycles later.
- Reset mid-operation: pull rst_n low at cycle 10 of a divide -> busy=0 and outputs=0 the next cycle, with no done pulse. A subsequent 100 / 7 completes normally.
- With NRDIV_SIGNED_EN: -7 / 2 -> quotient=32'hFFFF_FFFD, remainder=32'hFFFF_FFFF. 7 / -2 -> quotient=-3, remainder=1. 32'h8000_0000 / -1 -> quotient=32'h8000_0000, remainder=0.
